// File: rtl/tdm_demux_feeder_if.sv
// Handshake and serial-beat bundle between a TDM frame source and tdm_demux_feeder.
// The master side presents channel words and load; the slave side returns ready and the beat stream.
interface tdm_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             load;
  logic             ready;
  logic             i;
  logic [1:0]       sel;
  logic             valid;
  logic             last;

  modport master (
    output d0, d1, d2, d3, load,
    input  ready, i, sel, valid, last
  );

  modport slave (
    input  d0, d1, d2, d3, load,
    output ready, i, sel, valid, last
  );
endinterface

// File: rtl/tdm_demux_feeder.sv
// Serializes four channel words bit-interleaved (MSB first, slots 0..3) onto i/sel for a 1:4 demux.
// Optional macro TDM_PARITY_EN appends one even-parity beat per channel at the end of each frame.
module tdm_demux_feeder #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  tdm_if.slave  bus
);

`ifdef TDM_PARITY_EN
  localparam int SLOTS = WIDTH + 1;
`else
  localparam int SLOTS = WIDTH;
`endif
  localparam int BEATS = 4 * SLOTS;
  localparam int CW    = $clog2(BEATS);
  localparam int IW    = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
`ifdef TDM_PARITY_EN
  localparam logic [CW-3:0] PAR_POS = (CW-2)'(WIDTH);
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic [3:0][WIDTH-1:0]  shadow, shadow_next;
  logic                   i_q, i_next;
  logic [1:0]             sel_q, sel_next;
  logic                   valid_q, valid_next;
  logic                   last_q, last_next;

  logic                   accept;
  logic                   emit;
  logic [CW-1:0]          n;
  logic [CW-3:0]          pos;
  logic [3:0][WIDTH-1:0]  src;

  // The final beat doubles as an accept slot so back-to-back frames have no gap.
  assign bus.ready = (state == IDLE) || last_q;
  assign accept    = bus.load && bus.ready;

  assign bus.i     = i_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.last  = last_q;

  // NOTE: every signal written here gets a default first, otherwise a path that
  // skips an assignment holds the old value and a latch is inferred.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shadow_next = shadow;
    i_next      = 1'b0;
    sel_next    = 2'b00;
    valid_next  = 1'b0;
    last_next   = 1'b0;
    emit        = 1'b0;
    n           = '0;
    pos         = '0;
    src         = shadow;

    if (accept) begin
      shadow_next = {bus.d3, bus.d2, bus.d1, bus.d0};
      src         = {bus.d3, bus.d2, bus.d1, bus.d0};
      state_next  = SEND;
      emit        = 1'b1;
    end else if ((state == SEND) && !last_q) begin
      emit = 1'b1;
      n    = cnt + 1'b1;
    end else begin
      state_next = IDLE;
      cnt_next   = '0;
    end

    if (emit) begin
      pos        = n[CW-1:2];
      cnt_next   = n;
      sel_next   = n[1:0];
      valid_next = 1'b1;
      last_next  = (n == LAST_BEAT);
`ifdef TDM_PARITY_EN
      if (pos == PAR_POS) begin
        i_next = ^src[sel_next];
      end else begin
        i_next = src[sel_next][IW'(WIDTH - 1) - pos[IW-1:0]];
      end
`else
      i_next = src[sel_next][IW'(WIDTH - 1) - pos[IW-1:0]];
`endif
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the shadow words are reset too, so a frame never exposes power-up garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shadow  <= '0;
      i_q     <= 1'b0;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      shadow  <= shadow_next;
      i_q     <= i_next;
      sel_q   <= sel_next;
      valid_q <= valid_next;
      last_q  <= last_next;
    end
  end

endmodule

// File: tb/tb_tdm_demux_feeder.sv
// Directed bench for tdm_demux_feeder: a scoreboard of expected beats and demux-recovered words
// is filled when a load is driven and drained by a negedge monitor.
module tb_tdm_demux_feeder;

  localparam int W = 8;
`ifdef TDM_PARITY_EN
  localparam int B = 4 * (W + 1);
`else
  localparam int B = 4 * W;
`endif

  typedef struct packed {
    logic       i;
    logic [1:0] sel;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  tdm_if #(.WIDTH(W)) bus ();

  tdm_demux_feeder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  beat_t                beat_q[$];
  logic [3:0][W-1:0]    word_q[$];

  logic [W-1:0] rx [4];
  int           mon_beat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat stream, built straight from the frame format.
  task automatic push_frame(input logic [W-1:0] a0, input logic [W-1:0] a1,
                            input logic [W-1:0] a2, input logic [W-1:0] a3);
    logic [3:0][W-1:0] w;
    beat_t b;
    w = {a3, a2, a1, a0};
    for (int k = 0; k < B; k++) begin
      b.sel  = 2'(k % 4);
      b.i    = ((k / 4) < W) ? w[k % 4][W - 1 - (k / 4)] : ^w[k % 4];
      b.last = (k == B - 1);
      beat_q.push_back(b);
    end
    word_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard compare plus a model of the downstream 1:4 demux.
  always @(negedge clk) begin
    beat_t exp_b;
    logic [3:0][W-1:0] exp_w;
    if (rst) begin
      mon_beat = 0;
      for (int c = 0; c < 4; c++) rx[c] = '0;
    end else if (bus.valid === 1'b1) begin
      if (beat_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(bus.valid), 32'd0);
      end else begin
        exp_b = beat_q.pop_front();
        check("beat", 32'({bus.i, bus.sel, bus.last}), 32'(exp_b));
      end
      if (mon_beat < 4 * W) rx[bus.sel] = {rx[bus.sel][W-2:0], bus.i};
      mon_beat++;
      if (bus.last === 1'b1) begin
        if (word_q.size() != 0) begin
          exp_w = word_q.pop_front();
          for (int c = 0; c < 4; c++) check("demux_word", 32'(rx[c]), 32'(exp_w[c]));
        end
        mon_beat = 0;
      end
    end
  end

  initial begin
    logic [7:0] first8;
    int rdy_cnt;
    int last_cnt;

    // Reset with load held high: nothing may be captured.
    rst = 1'b1;
    bus.load = 1'b1;
    bus.d0 = 8'hDE; bus.d1 = 8'hAD; bus.d2 = 8'hBE; bus.d3 = 8'hEF;
    repeat (2) step();
    check("rst_outputs", 32'({bus.i, bus.sel, bus.valid, bus.last}), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    rst = 1'b0;
    bus.load = 1'b0;
    step();
    check("post_rst_idle", 32'(bus.valid), 32'd0);

    // Single frame; inputs scrambled right after accept, ignored load at beat 10.
    bus.d0 = 8'hA5; bus.d1 = 8'h3C; bus.d2 = 8'hFF; bus.d3 = 8'h00;
    bus.load = 1'b1;
    push_frame(8'hA5, 8'h3C, 8'hFF, 8'h00);
    step();
    bus.load = 1'b0;
    bus.d0 = 8'h5A; bus.d1 = 8'h5A; bus.d2 = 8'h5A; bus.d3 = 8'h5A;
    check("beat0", 32'({bus.valid, bus.i, bus.sel}), 32'b1_1_00);
    first8   = '0;
    last_cnt = 0;
    for (int b = 0; b < B; b++) begin
      if (b < 8) first8[7 - b] = bus.i;
      last_cnt += int'(bus.last);
      if (b == 5) check("ready_mid_frame", 32'(bus.ready), 32'd0);
      if (b == 10) begin
        bus.load = 1'b1;
        bus.d0 = 8'hFF; bus.d1 = 8'hFF; bus.d2 = 8'h00; bus.d3 = 8'h11;
      end
      if (b == 11) bus.load = 1'b0;
      if (b == B - 1) check("last_beat_ready", 32'({bus.last, bus.ready}), 32'b11);
      if (b < B - 1) step();
    end
    check("first8_bits", 32'(first8), 32'hA2);
    check("last_count", 32'(last_cnt), 32'd1);
    step();
    check("idle_after_frame", 32'({bus.valid, bus.i, bus.sel, bus.last}), 32'd0);

    // Back-to-back: load held high; new words become the second frame.
    bus.d0 = 8'h11; bus.d1 = 8'h22; bus.d2 = 8'h33; bus.d3 = 8'h44;
    bus.load = 1'b1;
    push_frame(8'h11, 8'h22, 8'h33, 8'h44);
    step();
    bus.d0 = 8'h01; bus.d1 = 8'h02; bus.d2 = 8'h04; bus.d3 = 8'h08;
    rdy_cnt = 0;
    for (int b = 0; b < B; b++) begin
      rdy_cnt += int'(bus.ready);
      if (b == B - 1) push_frame(8'h01, 8'h02, 8'h04, 8'h08);
      step();
    end
    check("b2b_ready_pulses", 32'(rdy_cnt), 32'd1);
    check("b2b_no_gap", 32'({bus.valid, bus.sel, bus.last}), 32'b1_00_0);
    bus.load = 1'b0;
    rdy_cnt  = 0;
    for (int b = 0; b < B; b++) begin
      rdy_cnt += int'(bus.ready);
      if (b < B - 1) step();
    end
    check("frame3_ready_pulses", 32'(rdy_cnt), 32'd1);
    step();
    check("idle_after_b2b", 32'(bus.valid), 32'd0);

    // Reset mid-frame at beat 12: outputs clear before the next edge.
    bus.d0 = 8'h12; bus.d1 = 8'h34; bus.d2 = 8'h56; bus.d3 = 8'h78;
    bus.load = 1'b1;
    push_frame(8'h12, 8'h34, 8'h56, 8'h78);
    step();
    bus.load = 1'b0;
    repeat (12) step();
    check("pre_rst_valid", 32'(bus.valid), 32'd1);
    #2 rst = 1'b1;
    beat_q.delete();
    word_q.delete();
    #1;
    check("async_rst_clear", 32'({bus.i, bus.sel, bus.valid, bus.last}), 32'd0);
    check("async_rst_ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.d0 = 8'hC3; bus.d1 = 8'h3C; bus.d2 = 8'h99; bus.d3 = 8'h66;
    bus.load = 1'b1;
    push_frame(8'hC3, 8'h3C, 8'h99, 8'h66);
    step();
    bus.load = 1'b0;
    check("restart_beat0", 32'({bus.valid, bus.i, bus.sel, bus.last}), 32'b1_1_00_0);
    repeat (B - 1) step();
    check("restart_last", 32'(bus.last), 32'd1);
    step();
    check("restart_idle", 32'(bus.valid), 32'd0);

    repeat (2) step();
    check("sb_beats_drained", 32'(beat_q.size()), 32'd0);
    check("sb_words_drained", 32'(word_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
